vending_ctrl_multi: RTL and testbench

Parametrised multi-product vending controller, the successor to the single-coffee controller in the lab vending path. It accepts 5- and 10-unit coins and NFC payment, sells one of N_PROD products at a common price, and returns change one coin per cycle. It also refunds on cancel or fault, and blocks sales while the water level is below a threshold. It sits between the coin/NFC front end and the per-product dispenser actuators.

---
 rtl/vending_ctrl_multi.sv | 228 ++++++++++++++++++++++
 tb/tb_vending_ctrl_multi.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vending_ctrl_multi.sv
// ---------------------------------------------------------------------------
// vending_ctrl_multi
//
// Multi-product vending controller. It accepts 5-unit (c5) and 10-unit (c10)
// coins and NFC payment, and sells one of N_PROD products at a common PRICE.
// Change is returned one 5-unit coin per cycle. Credit is refunded on cancel
// or on a water fault, and sales are blocked while the water level is below
// WATER_MIN.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   c5, c10   coin pulses (1 / 2 credit units)
//   nfc       NFC payment strobe
//   sel       one-hot product select, sampled every cycle
//   cancel    refund request pulse
//   stock     per-product availability (1 = available)
//   water     water level
//   dispense  one-hot actuator drive, held for DISP_CYC cycles
//   change    one pulse per returned 5-unit coin
//   reject    coin bounced (cycle after the offending coin)
//   credit    current credit in 5-unit coins
//   busy      high while dispensing or returning change
//   error     high while in the water-fault state
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module vending_ctrl_multi #(
  parameter int N_PROD     = 4,
  parameter int CREDIT_W   = 6,
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 6,
  parameter int WATER_W    = 5,
  parameter int WATER_MIN  = 4,
  parameter int DISP_CYC   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c5,
  input  logic                c10,
  input  logic                nfc,
  input  logic [N_PROD-1:0]   sel,
  input  logic                cancel,
  input  logic [N_PROD-1:0]   stock,
  input  logic [WATER_W-1:0]  water,
  output logic [N_PROD-1:0]   dispense,
  output logic                change,
  output logic                reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                error
);

  // The dispense counter only needs to hold DISP_CYC-1.
  localparam int CNT_W = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;

  localparam logic [CNT_W-1:0]    CNT_LOAD  = CNT_W'(DISP_CYC - 1);
  localparam logic [CNT_W-1:0]    CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_C     = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] CRED_ZERO = {CREDIT_W{1'b0}};
  localparam logic [CREDIT_W-1:0] CRED_ONE  = CREDIT_W'(1);
  localparam logic [N_PROD-1:0]   SEL_ZERO  = {N_PROD{1'b0}};
  localparam logic [N_PROD-1:0]   SEL_ONE   = N_PROD'(1);
  localparam logic [WATER_W-1:0]  WATER_TH  = WATER_W'(WATER_MIN);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CREDIT   = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_CHANGE   = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  state_t              state_r,     state_nxt_s;
  logic [CREDIT_W-1:0] credit_r,    credit_nxt_s;
  logic [CNT_W-1:0]    cnt_r,       cnt_nxt_s;
  logic [N_PROD-1:0]   sel_lat_r,   sel_lat_nxt_s;
  logic [N_PROD-1:0]   dispense_r,  dispense_nxt_s;
  logic                change_r,    change_nxt_s;
  logic                reject_r,    reject_nxt_s;
  logic                busy_r,      busy_nxt_s;
  logic                error_r,     error_nxt_s;

  logic                fault_s;
  logic                onehot_s;
  logic                sel_ok_s;
  logic                coin_s;
  logic                coin_ok_s;
  logic [CREDIT_W:0]   sum_s;
  logic                fits_s;

  assign fault_s  = (water < WATER_TH);
  assign onehot_s = (sel != SEL_ZERO) && ((sel & (sel - SEL_ONE)) == SEL_ZERO);
  assign sel_ok_s = onehot_s && ((sel & stock) != SEL_ZERO);
  assign coin_s   = c5 | c10;
  // {c10, c5} read as a binary number is exactly the increment: 1, 2 or 3.
  assign sum_s    = {1'b0, credit_r} + (CREDIT_W + 1)'({c10, c5});
  assign fits_s   = (sum_s <= MAX_C);

  assign dispense = dispense_r;
  assign change   = change_r;
  assign reject   = reject_r;
  assign credit   = credit_r;
  assign busy     = busy_r;
  assign error    = error_r;

  // State, credit, dispense bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      credit_r   <= CRED_ZERO;
      cnt_r      <= CNT_ZERO;
      sel_lat_r  <= SEL_ZERO;
      dispense_r <= SEL_ZERO;
      change_r   <= 1'b0;
      reject_r   <= 1'b0;
      busy_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      credit_r   <= credit_nxt_s;
      cnt_r      <= cnt_nxt_s;
      sel_lat_r  <= sel_lat_nxt_s;
      dispense_r <= dispense_nxt_s;
      change_r   <= change_nxt_s;
      reject_r   <= reject_nxt_s;
      busy_r     <= busy_nxt_s;
      error_r    <= error_nxt_s;
    end
  end

  // Next-state and credit arithmetic; priority fault > cancel > purchase > coin.
  always_comb begin
    state_nxt_s   = state_r;
    credit_nxt_s  = credit_r;
    cnt_nxt_s     = cnt_r;
    sel_lat_nxt_s = sel_lat_r;
    coin_ok_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_CREDIT: begin
        if (fault_s) begin
          // Any credit held is refunded before entering the error state.
          state_nxt_s = (credit_r != CRED_ZERO) ? ST_CHANGE : ST_ERROR;
        end else if (cancel && (state_r == ST_CREDIT)) begin
          state_nxt_s = (credit_r != CRED_ZERO) ? ST_CHANGE : ST_IDLE;
        end else if (sel_ok_s && (nfc || (credit_r >= PRICE_C))) begin
          state_nxt_s   = ST_DISPENSE;
          cnt_nxt_s     = CNT_LOAD;
          sel_lat_nxt_s = sel;
          // NFC pays in full, so coin credit is kept for refund later.
          if (nfc) begin
            credit_nxt_s = credit_r;
          end else begin
            credit_nxt_s = credit_r - PRICE_C;
          end
        end else if (coin_s && fits_s) begin
          coin_ok_s    = 1'b1;
          credit_nxt_s = sum_s[CREDIT_W-1:0];
          state_nxt_s  = ST_CREDIT;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DISPENSE: begin
        if (cnt_r == CNT_ZERO) begin
          sel_lat_nxt_s = SEL_ZERO;
          state_nxt_s   = (credit_r != CRED_ZERO) ? ST_CHANGE : ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_CHANGE: begin
        if (credit_r != CRED_ZERO) begin
          credit_nxt_s = credit_r - CRED_ONE;
        end else begin
          credit_nxt_s = CRED_ZERO;
        end
        // Leave on the cycle that returns the last coin.
        if (credit_r <= CRED_ONE) begin
          state_nxt_s = fault_s ? ST_ERROR : ST_IDLE;
        end else begin
          state_nxt_s = ST_CHANGE;
        end
      end
      ST_ERROR: begin
        if (!fault_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ERROR;
        end
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        credit_nxt_s  = CRED_ZERO;
        cnt_nxt_s     = CNT_ZERO;
        sel_lat_nxt_s = SEL_ZERO;
      end
    endcase
  end

  // Output values, derived from the next state so they line up with it.
  always_comb begin
    dispense_nxt_s = SEL_ZERO;
    change_nxt_s   = 1'b0;
    busy_nxt_s     = 1'b0;
    error_nxt_s    = 1'b0;
    // Every coin that is not taken into credit bounces.
    reject_nxt_s   = coin_s && !coin_ok_s;
    case (state_nxt_s)
      ST_DISPENSE: begin
        dispense_nxt_s = sel_lat_nxt_s;
        busy_nxt_s     = 1'b1;
      end
      ST_CHANGE: begin
        change_nxt_s = 1'b1;
        busy_nxt_s   = 1'b1;
      end
      ST_ERROR: begin
        error_nxt_s = 1'b1;
      end
      default: begin
        dispense_nxt_s = SEL_ZERO;
      end
    endcase
  end

endmodule

// File: tb/tb_vending_ctrl_multi.sv
module tb_vending_ctrl_multi;

  logic       clk;
  logic       rst;
  logic       c5, c10, nfc, cancel;
  logic [3:0] sel, stock;
  logic [4:0] water;
  logic [3:0] dispense;
  logic       change, reject, busy, error;
  logic [5:0] credit;

  int n_checks;
  int n_fail;

  vending_ctrl_multi dut (
    .clk      (clk),
    .rst      (rst),
    .c5       (c5),
    .c10      (c10),
    .nfc      (nfc),
    .sel      (sel),
    .cancel   (cancel),
    .stock    (stock),
    .water    (water),
    .dispense (dispense),
    .change   (change),
    .reject   (reject),
    .credit   (credit),
    .busy     (busy),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) tick();
    n_checks++; if (credit !== 6'd0) begin n_fail++; $display("FAIL reset_credit got %0d exp 0", credit); end
    n_checks++; if ({dispense, change, reject, busy, error} !== 8'd0) begin n_fail++; $display("FAIL reset_outputs got %b exp 0", {dispense, change, reject, busy, error}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    c10 = 1'b1; tick(); c10 = 1'b0;
    n_checks++; if (credit !== 6'd2) begin n_fail++; $display("FAIL basic_c10 credit got %0d exp 2", credit); end
    c5 = 1'b1; tick(); c5 = 1'b0;
    n_checks++; if (credit !== 6'd3) begin n_fail++; $display("FAIL basic_c5 credit got %0d exp 3", credit); end
    sel = 4'b0010; tick(); sel = 4'b0000;
    n_checks++; if (credit !== 6'd0) begin n_fail++; $display("FAIL basic_buy credit got %0d exp 0", credit); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (dispense !== 4'b0010 || busy !== 1'b1 || change !== 1'b0) begin n_fail++; $display("FAIL basic_disp cyc %0d disp %b busy %b chg %b exp 0010 1 0", i, dispense, busy, change); end
      tick();
    end
    n_checks++; if (dispense !== 4'b0000 || busy !== 1'b0 || change !== 1'b0) begin n_fail++; $display("FAIL basic_end disp %b busy %b chg %b exp 0000 0 0", dispense, busy, change); end
  endtask

  task automatic test_change;
    int cnt;
    c10 = 1'b1; tick(); tick(); c10 = 1'b0;
    n_checks++; if (credit !== 6'd4) begin n_fail++; $display("FAIL chg_credit got %0d exp 4", credit); end
    sel = 4'b0001; tick(); sel = 4'b0000;
    n_checks++; if (dispense !== 4'b0001 || credit !== 6'd1) begin n_fail++; $display("FAIL chg_disp disp %b credit %0d exp 0001 1", dispense, credit); end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (change) cnt++;
      tick();
    end
    n_checks++; if (cnt !== 1) begin n_fail++; $display("FAIL chg_pulses got %0d exp 1", cnt); end
    n_checks++; if (credit !== 6'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL chg_end credit %0d busy %b exp 0 0", credit, busy); end
  endtask

  task automatic test_reject_cancel;
    int cnt;
    c10 = 1'b1; tick(); tick(); c10 = 1'b0;
    c5 = 1'b1; tick(); c5 = 1'b0;
    n_checks++; if (credit !== 6'd5) begin n_fail++; $display("FAIL rc_credit got %0d exp 5", credit); end
    c10 = 1'b1; tick(); c10 = 1'b0;
    n_checks++; if (reject !== 1'b1 || credit !== 6'd5) begin n_fail++; $display("FAIL rc_reject rej %b credit %0d exp 1 5", reject, credit); end
    tick();
    n_checks++; if (reject !== 1'b0) begin n_fail++; $display("FAIL rc_reject_pulse got %b exp 0", reject); end
    cancel = 1'b1; tick(); cancel = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (change) cnt++;
      tick();
    end
    n_checks++; if (cnt !== 5) begin n_fail++; $display("FAIL rc_cancel_pulses got %0d exp 5", cnt); end
    n_checks++; if (credit !== 6'd0 || busy !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL rc_end credit %0d busy %b err %b exp 0 0 0", credit, busy, error); end
  endtask

  task automatic test_nfc;
    int cnt;
    c10 = 1'b1; tick(); c10 = 1'b0;
    sel = 4'b1000; nfc = 1'b1; tick(); sel = 4'b0000; nfc = 1'b0;
    n_checks++; if (dispense !== 4'b1000 || credit !== 6'd2) begin n_fail++; $display("FAIL nfc_disp disp %b credit %0d exp 1000 2", dispense, credit); end
    tick(); tick();
    n_checks++; if (dispense !== 4'b1000 || credit !== 6'd2) begin n_fail++; $display("FAIL nfc_disp_last disp %b credit %0d exp 1000 2", dispense, credit); end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (change) cnt++;
      tick();
    end
    n_checks++; if (cnt !== 2 || credit !== 6'd0) begin n_fail++; $display("FAIL nfc_change pulses %0d credit %0d exp 2 0", cnt, credit); end
  endtask

  task automatic test_invalid;
    int cnt;
    c10 = 1'b1; tick(); tick(); c10 = 1'b0;
    sel = 4'b0110; tick(); sel = 4'b0000;
    n_checks++; if (dispense !== 4'b0000 || credit !== 6'd4) begin n_fail++; $display("FAIL inv_multihot disp %b credit %0d exp 0000 4", dispense, credit); end
    stock = 4'b1110; sel = 4'b0001; tick(); sel = 4'b0000; stock = 4'b1111;
    n_checks++; if (dispense !== 4'b0000 || credit !== 6'd4) begin n_fail++; $display("FAIL inv_nostock disp %b credit %0d exp 0000 4", dispense, credit); end
    sel = 4'b0100; tick(); sel = 4'b0000;
    n_checks++; if (dispense !== 4'b0100 || credit !== 6'd1) begin n_fail++; $display("FAIL inv_buy disp %b credit %0d exp 0100 1", dispense, credit); end
    c5 = 1'b1; tick(); c5 = 1'b0;
    n_checks++; if (reject !== 1'b1 || credit !== 6'd1 || dispense !== 4'b0100) begin n_fail++; $display("FAIL inv_busy_coin rej %b credit %0d disp %b exp 1 1 0100", reject, credit, dispense); end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (change) cnt++;
      tick();
    end
    n_checks++; if (cnt !== 1 || credit !== 6'd0) begin n_fail++; $display("FAIL inv_change pulses %0d credit %0d exp 1 0", cnt, credit); end
  endtask

  task automatic test_fault;
    int cnt;
    c5 = 1'b1; tick(); c5 = 1'b0;
    c10 = 1'b1; tick(); c10 = 1'b0;
    water = 5'd2; tick();
    n_checks++; if (change !== 1'b1 || credit !== 6'd3 || error !== 1'b0) begin n_fail++; $display("FAIL flt_refund chg %b credit %0d err %b exp 1 3 0", change, credit, error); end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (change) cnt++;
      tick();
    end
    n_checks++; if (cnt !== 3 || error !== 1'b1 || credit !== 6'd0) begin n_fail++; $display("FAIL flt_error pulses %0d err %b credit %0d exp 3 1 0", cnt, error, credit); end
    water = 5'd10; tick();
    n_checks++; if (error !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flt_clear err %b busy %b exp 0 0", error, busy); end
    water = 5'd2; tick();
    n_checks++; if (error !== 1'b1 || change !== 1'b0) begin n_fail++; $display("FAIL flt_idle err %b chg %b exp 1 0", error, change); end
    water = 5'd10; tick();
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL flt_idle_clear err %b exp 0", error); end
  endtask

  task automatic test_reset_mid;
    c10 = 1'b1; tick(); tick(); c10 = 1'b0;
    c5 = 1'b1; tick(); c5 = 1'b0;
    cancel = 1'b1; tick(); cancel = 1'b0;
    tick();
    n_checks++; if (change !== 1'b1 || credit !== 6'd4) begin n_fail++; $display("FAIL rm_change chg %b credit %0d exp 1 4", change, credit); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({dispense, change, reject, busy, error} !== 8'd0 || credit !== 6'd0) begin n_fail++; $display("FAIL rm_async outs %b credit %0d exp 0 0", {dispense, change, reject, busy, error}, credit); end
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (change !== 1'b0 || credit !== 6'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_after chg %b credit %0d busy %b exp 0 0 0", change, credit, busy); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    c5       = 1'b0;
    c10      = 1'b0;
    nfc      = 1'b0;
    cancel   = 1'b0;
    sel      = 4'b0000;
    stock    = 4'b1111;
    water    = 5'd10;
    #2;
    test_reset();
    test_basic();
    test_change();
    test_reject_cancel();
    test_nfc();
    test_invalid();
    test_fault();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
